float_square_seq: RTL
=====================

FLOAT_SQUARE_SEQ -- requirements
Module: float_square_seq

Interface
REQ-001 The module SHALL take parameter XLEN, default 32, the IEEE-754 single-precision operand and result width; only 32 is supported.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port start, input, 1 bit: request to square A, sampled only in IDLE.
REQ-005 Port A, input, XLEN bits: IEEE-754 operand, captured on the accepting edge.
REQ-006 Port busy, output, 1 bit: high from the accepting edge until done deasserts.
REQ-007 Port done, output, 1 bit: single-cycle pulse; result and flags are valid in this cycle.
REQ-008 Port result, output, XLEN bits: A*A in IEEE-754, held until the next accepted start.
REQ-009 Ports overflow, underflow, exception, output, 1 bit each: status flags, held with result.

Function
REQ-010 The FSM SHALL have states IDLE, MUL, NORM and DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-011 In IDLE, start=1 SHALL capture A, clear the flags and set busy; a normal operand SHALL enter MUL, and a special operand (REQ-016, REQ-017) SHALL enter DONE directly.
REQ-012 MUL SHALL run a 24-bit x 24-bit shift-add product of {1,mantissa} with itself into a 48-bit accumulator, one multiplier bit per cycle, for exactly 24 cycles under a 5-bit counter.
REQ-013 NORM SHALL normalise the product: if bit 47 is set, use P[46:24] and exponent 2E-126; otherwise use P[45:23] and exponent 2E-127, computed in at least 10-bit signed arithmetic.
REQ-014 Result sign SHALL always be 0, whatever the sign of A.
REQ-015 Exponent handling:
- biased exponent >= 255: result = 32'h7F800000 and overflow = 1.
- biased exponent <= 0: result = 0 and underflow = 1.
REQ-016 If A[30:23] = 0 (zero or denormal), the result SHALL be 32'h00000000 with all flags 0.
REQ-017 If A[30:23] = 255, then exception = 1 and result = {1'b0, 8'hFF, A[22:0]}, so infinity stays infinity and NaN stays NaN.
REQ-018 Latency SHALL be fixed:
- normal operand: done asserts 26 cycles after the accepting edge.
- special operand: done asserts 1 cycle after the accepting edge.
REQ-019 start SHALL be ignored while busy = 1, including in the DONE cycle.
REQ-020 result and the flags SHALL change only on the edge that enters DONE.

Reset
REQ-021 While rst = 1, the state SHALL be IDLE and busy, done, result, overflow, underflow and exception SHALL all be 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow, and the next start after rst falls SHALL be accepted normally.

Configuration
REQ-023 With macro FLOAT_SQUARE_ROUND_EN defined, NORM SHALL apply round-to-nearest-even on the discarded product bits; a mantissa carry-out SHALL increment the exponent and be rechecked against REQ-015.
REQ-024 Without FLOAT_SQUARE_ROUND_EN, NORM SHALL truncate the discarded bits; latency SHALL be identical in both builds.

Verification
REQ-025 A=32'h40A00000 (5.0) with a start pulse -> 26 cycles later done=1, result=32'h41C80000 (25.0), all flags 0.
REQ-026 A=32'hC0800000 (-4.0), then A=32'h3FC00000 (1.5), back-to-back -> results 32'h41800000 (16.0) and 32'h40100000 (2.25); a start pulse asserted while busy is ignored.
REQ-027 A=32'h60000000 (2^65) -> result 32'h7F800000 with overflow=1; A=32'h1F000000 (2^-65) -> result 0 with underflow=1.
REQ-028 A=32'h7F800000 -> done after 1 cycle, exception=1, result 32'h7F800000; A=32'h00000000 -> result 0, flags 0.
REQ-029 rst pulsed at cycle 10 of a MUL sequence -> all outputs 0 and no done pulse; a following start with A=32'h40400000 (3.0) -> result 32'h41100000 (9.0).

Source files
------------

// File: rtl/float_square_seq.sv
// float_square_seq: sequential IEEE-754 single-precision squarer.
// A 24x24 shift-add multiplier squares {1,mantissa}, one multiplier bit per
// cycle, then a normalise step builds the result and overflow/underflow flags.
// Zero/denormal and inf/NaN operands skip the multiplier and finish at once.
// Build option: define FLOAT_SQUARE_ROUND_EN for round-to-nearest-even in the
// normalise step; without it the discarded product bits are truncated.
// Handshake: start is sampled only while busy=0; the accepting edge raises
// busy; done pulses for one cycle with result/flags valid, after which busy
// drops. result and flags change only on the edge that enters DONE and are
// held until then.
// dbg_state exposes the FSM state: 0=IDLE, 1=MUL, 2=NORM, 3=DONE.
module float_square_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [7:0]  exp_q;     // captured biased exponent
  logic [47:0] mcand_q;   // multiplicand, shifted left each MUL cycle
  logic [23:0] mplier_q;  // multiplier, shifted right each MUL cycle
  logic [47:0] acc_q;     // product accumulator
  logic [4:0]  cnt_q;     // MUL step counter

  logic        special;
  logic        unused_sign;

  logic signed [10:0] norm_exp;
  logic [22:0]        mant_t;
  logic [22:0]        mant_r;
  logic [31:0]        norm_res;
  logic               norm_ov;
  logic               norm_un;
`ifdef FLOAT_SQUARE_ROUND_EN
  logic        grd;
  logic        stk;
  logic        rnd;
  logic [23:0] mant_sum;
`endif

  // The square is always non-negative, so the operand sign is never used.
  assign unused_sign = A[31];
  assign special     = (A[30:23] == 8'h00) || (A[30:23] == 8'hFF);

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = special ? DONE : MUL;
      MUL:  if (cnt_q == 5'd23) state_d = NORM;
      NORM: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Normalise the 48-bit product into an exponent/mantissa pair and flags.
  always_comb begin
    if (acc_q[47]) begin
      mant_t   = acc_q[46:24];
      norm_exp = $signed({2'b00, exp_q, 1'b0}) - 11'sd126;
    end else begin
      mant_t   = acc_q[45:23];
      norm_exp = $signed({2'b00, exp_q, 1'b0}) - 11'sd127;
    end
`ifdef FLOAT_SQUARE_ROUND_EN
    grd      = acc_q[47] ? acc_q[23] : acc_q[22];
    stk      = acc_q[47] ? (|acc_q[22:0]) : (|acc_q[21:0]);
    rnd      = grd & (stk | mant_t[0]);
    mant_sum = {1'b0, mant_t} + {23'd0, rnd};
    mant_r   = mant_sum[22:0];
    // A carry out of the mantissa leaves it zero and bumps the exponent.
    if (mant_sum[23]) norm_exp = norm_exp + 11'sd1;
`else
    mant_r = mant_t;
`endif
    norm_ov  = 1'b0;
    norm_un  = 1'b0;
    norm_res = {1'b0, norm_exp[7:0], mant_r};
    if (norm_exp >= 11'sd255) begin
      norm_res = 32'h7F80_0000;
      norm_ov  = 1'b1;
    end else if (norm_exp <= 11'sd0) begin
      norm_res = 32'h0000_0000;
      norm_un  = 1'b1;
    end
  end

  // Datapath: operand capture, shift-add steps and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q    <= A[30:23];
            mcand_q  <= {24'd0, 1'b1, A[22:0]};
            mplier_q <= {1'b1, A[22:0]};
            acc_q    <= '0;
            cnt_q    <= '0;
            // Specials enter DONE on this edge, so their outputs land now.
            if (special) begin
              overflow  <= 1'b0;
              underflow <= 1'b0;
              if (A[30:23] == 8'hFF) begin
                result    <= {1'b0, 8'hFF, A[22:0]};
                exception <= 1'b1;
              end else begin
                result    <= '0;
                exception <= 1'b0;
              end
            end
          end
        end
        MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= {mcand_q[46:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[23:1]};
          cnt_q    <= cnt_q + 5'd1;
        end
        NORM: begin
          result    <= norm_res;
          overflow  <= norm_ov;
          underflow <= norm_un;
          exception <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
